seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner.sv | 105 ++++++++++
 tb/tb_seven_seg_scanner.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Six-digit common-anode 7-segment scanner: shadow-latches d1..d6 on load and
// time-multiplexes them with a one-cycle blank guard per slot. Option: SEVEN_SEG_BLANK_EN.
module seven_seg_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       shadow_q [6];
  logic             slot_end;
  logic             blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  assign slot_end = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (load) begin
        shadow_q[0] <= d1;
        shadow_q[1] <= d2;
        shadow_q[2] <= d3;
        shadow_q[3] <= d4;
        shadow_q[4] <= d5;
        shadow_q[5] <= d6;
      end
    end
  end

`ifdef SEVEN_SEG_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero;
  // the rightmost digit always shows so a zero value still reads "0".
  logic lead_zero;
  always_comb begin
    lead_zero = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if ((3'(j) <= idx_q) && (shadow_q[j] != 4'd0)) lead_zero = 1'b0;
    end
    blank = lead_zero && (idx_q != 3'd5);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an  = 6'b111111;
    seg = 7'b1111111;
    if ((cnt_q != '0) && !blank) begin
      an  = ~(6'b000001 << idx_q);
      seg = seg_decode(shadow_q[idx_q]);
    end
    frame_tick = slot_end && (idx_q == 3'd5);
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at SCAN_DIV=4: frame vectors from a
// table plus hand-written reset, mid-slot load and reset-priority sequences.
module tb_seven_seg_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0, d5 = 4'd0, d6 = 4'd0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  int tests = 0;
  int failed = 0;

  seven_seg_scanner #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .load(load),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;      // d1 in [23:20] .. d6 in [3:0]
    logic [41:0] s;      // slot 0 segments in [41:35] .. slot 5 in [6:0]
    logic [5:0]  blank;  // bit k: slot k stays dark
  } vec_t;

  vec_t vecs [6];

`ifdef SEVEN_SEG_BLANK_EN
  localparam logic BLANK_ON = 1'b1;
`else
  localparam logic BLANK_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [5:0] a_an, input logic [6:0] a_seg,
                       input logic a_ft, input logic [5:0] e_an, input logic [6:0] e_seg,
                       input logic e_ft);
    tests++;
    if ({a_an, a_seg, a_ft} !== {e_an, e_seg, e_ft}) begin
      failed++;
      $display("FAIL %s: an=%b seg=%b tick=%b, expected an=%b seg=%b tick=%b",
               name, a_an, a_seg, a_ft, e_an, e_seg, e_ft);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, load on the first free-running edge, run to the next frame start,
  // then check all 24 cycles of one frame.
  task automatic run_frame(input int v);
    logic [5:0] e_an;
    logic [6:0] e_seg;
    int idx;
    reset = 1'b1; load = 1'b0;
    tick();
    reset = 1'b0; load = 1'b1;
    {d1, d2, d3, d4, d5, d6} = vecs[v].d;
    tick();
    load = 1'b0;
    repeat (6 * SD - 1) tick();
    for (int m = 0; m < 6 * SD; m++) begin
      idx = m / SD;
      if ((m % SD == 0) || vecs[v].blank[idx]) begin
        e_an = 6'b111111; e_seg = 7'b1111111;
      end else begin
        e_an = ~(6'b000001 << idx);
        e_seg = vecs[v].s[41 - 7 * idx -: 7];
      end
      check($sformatf("frame%0d_c%0d", v, m), an, seg, frame_tick, e_an, e_seg, m == 6 * SD - 1);
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{24'h123456, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 6'b0};
    vecs[1] = '{24'hABCDEF, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}, 6'b0};
    vecs[2] = '{24'h000023, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0100100, 7'b0110000},
                BLANK_ON ? 6'b001111 : 6'b0};
    vecs[3] = '{24'h000000, {6{7'b1000000}}, BLANK_ON ? 6'b011111 : 6'b0};
    vecs[4] = '{24'h987001, {7'b0010000, 7'b0000000, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1111001}, 6'b0};
    vecs[5] = '{24'h0F0000, {7'b1000000, 7'b0001110, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                BLANK_ON ? 6'b000001 : 6'b0};

    // Reset held for three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold%0d", i), an, seg, frame_tick, 6'b111111, 7'b1111111, 1'b0);
    end
    reset = 1'b0;
    tick();
    if (BLANK_ON) check("first_lit", an, seg, frame_tick, 6'b111111, 7'b1111111, 1'b0);
    else          check("first_lit", an, seg, frame_tick, 6'b111110, 7'b1000000, 1'b0);

    for (int v = 0; v < 6; v++) run_frame(v);

    // Mid-slot and back-to-back loads while digit 0 is lit.
    reset = 1'b1; tick();
    reset = 1'b0; load = 1'b1;
    {d1, d2, d3, d4, d5, d6} = 24'h700000;
    tick();                                   // cnt=1, idx=0
    check("mid_before", an, seg, frame_tick, 6'b111110, 7'b1111000, 1'b0);
    d1 = 4'd8;
    tick();                                   // cnt=2
    check("mid_load8", an, seg, frame_tick, 6'b111110, 7'b0000000, 1'b0);
    d1 = 4'd2;
    tick();                                   // cnt=3
    check("b2b_load2", an, seg, frame_tick, 6'b111110, 7'b0100100, 1'b0);
    load = 1'b0;
    tick();                                   // guard of slot 1
    check("mid_guard", an, seg, frame_tick, 6'b111111, 7'b1111111, 1'b0);
    tick();                                   // slot 1 lit, shadow[1]=0
    check("mid_slot1", an, seg, frame_tick, 6'b111101, 7'b1000000, 1'b0);

    // Reset mid-scan with a simultaneous load of all nines.
    reset = 1'b1; load = 1'b1;
    {d1, d2, d3, d4, d5, d6} = 24'h999999;
    tick();
    check("rst_pri_hold", an, seg, frame_tick, 6'b111111, 7'b1111111, 1'b0);
    reset = 1'b0; load = 1'b0;
    tick();
    if (BLANK_ON) check("rst_pri_lit", an, seg, frame_tick, 6'b111111, 7'b1111111, 1'b0);
    else          check("rst_pri_lit", an, seg, frame_tick, 6'b111110, 7'b1000000, 1'b0);
    repeat (5 * SD) tick();                   // slot 5, cnt=1: zero still shown
    check("rst_pri_d6", an, seg, frame_tick, 6'b011111, 7'b1000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
